associative_memory_folded: RTL
==============================

Name: associative_memory_folded

Overview:
- Classification stage directly downstream of the folded temporal encoder.
- Consumes one query hypervector as NUM_FOLDS sequential FOLD_WIDTH-bit folds, most-significant fold first.
- Accumulates the Hamming distance to each class prototype, fold by fold, then emits the arg-min class label over a valid/ready handshake.
- Prototype folds come from an external asynchronous-read prototype memory addressed by this block's fold_idx.

Parameters:
- NUM_FOLDS, 10: folds per hypervector; 1 means no folding.
- NUM_FOLDS_WIDTH, 4: ceillog(NUM_FOLDS); minimum 1.
- FOLD_WIDTH, 200: bits per fold; NUM_FOLDS*FOLD_WIDTH equals `HV_DIMENSION (2000).
- NUM_CLASSES, 2: number of prototypes.
- CLASS_WIDTH, 1: ceillog(NUM_CLASSES); minimum 1.

Ports:
- clk  in  1  single clock; all state on posedge.
- rst  in  1  asynchronous, active-high reset.
- hvin_valid  in  1  query fold valid.
- hvin_ready  out  1  block can accept a query fold.
- hvin  in  FOLD_WIDTH  current query fold.
- fold_idx  out  NUM_FOLDS_WIDTH  fold being consumed, counting NUM_FOLDS-1 down to 0; drives the prototype memory address.
- prototype_fold  in  NUM_CLASSES*FOLD_WIDTH  prototype slice for fold_idx, valid in the same cycle; class c occupies bits [c*FOLD_WIDTH +: FOLD_WIDTH].
- class_valid  out  1  classification result valid.
- class_ready  in  1  downstream accepts the result.
- class_out  out  CLASS_WIDTH  arg-min class index.

Behaviour:
- Reset (asynchronous, immediate on rst high):
  - state=S_ACCUM, fold_idx=NUM_FOLDS-1, all dist[c]=0.
  - class_valid=0, class_out=0, hvin_ready=1 once the state is S_ACCUM.
- Distance width: DIST_WIDTH = ceillog(`HV_DIMENSION+1) = 11.
- Per-fold popcount width: ceillog(FOLD_WIDTH+1). Accumulation is unsigned and cannot overflow by construction.
- S_ACCUM:
  - hvin_ready=1; fire = hvin_valid && hvin_ready.
  - On fire, for every c: dist[c] <= dist[c] + popcount(hvin ^ prototype_fold[c]).
  - On fire with fold_idx != 0: fold_idx decrements.
  - On fire with fold_idx == 0: go to S_COMPARE and reload fold_idx to NUM_FOLDS-1.
  - With no fire, hold all state; gaps in hvin_valid are legal.
- S_COMPARE (exactly one cycle):
  - hvin_ready=0.
  - class_out <= index of minimum dist; ties resolve to the lowest index.
  - Next state S_OUTPUT.
- S_OUTPUT:
  - class_valid=1, hvin_ready=0.
  - class_out and dist are held stable under backpressure.
  - On class_valid && class_ready: clear all dist[c] to 0, class_valid <= 0, go to S_ACCUM. The next fold may fire the following cycle.
- Latency: last fold fires at cycle t; class_valid is high at t+2. Throughput is one result per NUM_FOLDS+2 cycles at full rate.
- The input fold handshake and the output handshake never overlap, so there are no simultaneous input/output events.
- NUM_FOLDS=1: every fire takes the last-fold path directly.
- Reset mid-query discards the partial distances; the next fold fires as fold NUM_FOLDS-1.

Optional Feature:
- Macro: AM_DISTANCE_OUT_EN.
- Defined: adds output port dist_out [DIST_WIDTH-1:0]. It carries the winning class's accumulated distance, registered in S_COMPARE alongside class_out and stable while class_valid is high. Its reset value is 0.
- Undefined: the port and its register are absent; the rest of the behaviour is identical.

Decomposition:
- const.vh: HV_DIMENSION (already present), NUM_CLASSES, DIST_WIDTH, and the state encodings S_ACCUM/S_COMPARE/S_OUTPUT.
- Sub-module fold_popcount: parameter WIDTH; input vector; output count of width ceillog(WIDTH+1); purely combinational.
- The top level instantiates one fold_popcount per class.

Test Plan:
- Prototype 0 all-zero, prototype 1 all-one, ten all-zero folds -> class_out=0, dist_out=0, class_valid exactly 2 cycles after the 10th fire; fold_idx sequence 9,8,...,0.
- Same prototypes, ten all-one folds -> class_out=1, dist_out=0.
- Tie: each fold has exactly 100 ones -> both distances 1000 -> class_out=0, dist_out=1000.
- Backpressure: class_ready low for 5 cycles after class_valid -> hvin_ready stays 0, class_out stable. After the handshake, the next query's distances start from 0 and fold_idx=9.
- Random hvin_valid gaps (~50% duty) with random prototypes -> class_out and dist_out match a reference-model Hamming arg-min.
- rst pulsed after 4 fold fires -> class_valid=0 and fold_idx=9 immediately; a subsequent full query classifies correctly with no residue from the aborted one.

Source files
------------

// File: rtl/associative_memory_folded_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | associative_memory_folded_pkg                                              |
// | Shared constants and FSM encoding for the folded associative memory.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package associative_memory_folded_pkg;

  localparam int c_hv_dimension = 2000;
  localparam int c_num_classes  = 2;
  localparam int c_dist_width   = $clog2(c_hv_dimension + 1);

  typedef enum logic [1:0] {
    S_ACCUM   = 2'd0,
    S_COMPARE = 2'd1,
    S_OUTPUT  = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/associative_memory_folded_fold_popcount.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fold_popcount                                                              |
// | Combinational population count of one WIDTH-bit fold.                      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module fold_popcount #(
  parameter int WIDTH = 200
) (
  input  logic [WIDTH-1:0]             vec,
  output logic [$clog2(WIDTH+1)-1:0]   count
);

  localparam int c_cw = $clog2(WIDTH + 1);

  always_comb begin
    count = '0;
    for (int i = 0; i < WIDTH; i++) begin
      count = count + c_cw'(vec[i]);
    end
  end

endmodule
`default_nettype wire

// File: rtl/associative_memory_folded.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | associative_memory_folded                                                  |
// | Fold-serial Hamming-distance classifier; emits the arg-min class label.    |
// | Optional macro AM_DISTANCE_OUT_EN adds dist_out (winning distance).        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module associative_memory_folded
  import associative_memory_folded_pkg::*;
#(
  parameter int NUM_FOLDS       = 10,
  parameter int NUM_FOLDS_WIDTH = 4,
  parameter int FOLD_WIDTH      = 200,
  parameter int NUM_CLASSES     = c_num_classes,
  parameter int CLASS_WIDTH     = 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              hvin_valid,
  output logic                              hvin_ready,
  input  logic [FOLD_WIDTH-1:0]             hvin,
  output logic [NUM_FOLDS_WIDTH-1:0]        fold_idx,
  input  logic [NUM_CLASSES*FOLD_WIDTH-1:0] prototype_fold,
  output logic                              class_valid,
  input  logic                              class_ready,
  output logic [CLASS_WIDTH-1:0]            class_out
`ifdef AM_DISTANCE_OUT_EN
  ,
  output logic [c_dist_width-1:0]           dist_out
`endif
);

  localparam int                       c_pw        = $clog2(FOLD_WIDTH + 1);
  localparam logic [NUM_FOLDS_WIDTH-1:0] c_last_fold = NUM_FOLDS_WIDTH'(NUM_FOLDS - 1);

  state_t                      r_state;
  state_t                      w_state_next;
  logic [NUM_FOLDS_WIDTH-1:0]  r_fold_idx;
  logic [c_dist_width-1:0]     r_dist [NUM_CLASSES];
  logic [c_pw-1:0]             w_pop  [NUM_CLASSES];
  logic [CLASS_WIDTH-1:0]      r_class_out;
  logic [CLASS_WIDTH-1:0]      w_min_idx;
  logic [c_dist_width-1:0]     w_min_dist;
  logic                        w_fire;
  logic                        w_accept;

  for (genvar c = 0; c < NUM_CLASSES; c++) begin : g_class
    fold_popcount #(.WIDTH(FOLD_WIDTH)) u_popcount (
      .vec   (hvin ^ prototype_fold[c*FOLD_WIDTH +: FOLD_WIDTH]),
      .count (w_pop[c])
    );
  end

  // Strict less-than keeps the lowest index on ties.
  always_comb begin
    w_min_idx  = '0;
    w_min_dist = r_dist[0];
    for (int c = 1; c < NUM_CLASSES; c++) begin
      if (r_dist[c] < w_min_dist) begin
        w_min_dist = r_dist[c];
        w_min_idx  = CLASS_WIDTH'(c);
      end
    end
  end

  assign hvin_ready  = (r_state == S_ACCUM);
  assign class_valid = (r_state == S_OUTPUT);
  assign w_fire      = hvin_valid && hvin_ready;
  assign w_accept    = class_valid && class_ready;
  assign fold_idx    = r_fold_idx;
  assign class_out   = r_class_out;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_ACCUM;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_ACCUM:   if (w_fire && r_fold_idx == '0) w_state_next = S_COMPARE;
      S_COMPARE: w_state_next = S_OUTPUT;
      S_OUTPUT:  if (w_accept) w_state_next = S_ACCUM;
      default:   w_state_next = S_ACCUM;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fold_idx  <= c_last_fold;
      r_class_out <= '0;
      for (int c = 0; c < NUM_CLASSES; c++) r_dist[c] <= '0;
    end else begin
      case (r_state)
        S_ACCUM: begin
          if (w_fire) begin
            for (int c = 0; c < NUM_CLASSES; c++) begin
              r_dist[c] <= r_dist[c] + c_dist_width'(w_pop[c]);
            end
            r_fold_idx <= (r_fold_idx == '0) ? c_last_fold
                                             : r_fold_idx - NUM_FOLDS_WIDTH'(1);
          end
        end
        S_COMPARE: r_class_out <= w_min_idx;
        S_OUTPUT: begin
          if (w_accept) begin
            for (int c = 0; c < NUM_CLASSES; c++) r_dist[c] <= '0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef AM_DISTANCE_OUT_EN
  logic [c_dist_width-1:0] r_dist_out;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        r_dist_out <= '0;
    else if (r_state == S_COMPARE)  r_dist_out <= w_min_dist;
  end

  assign dist_out = r_dist_out;
`endif

endmodule
`default_nettype wire
